regfile_wb_arbiter: RTL and testbench

- Initiator side of the 32x32 register file write port.
- Merges ALU and load-unit writeback traffic and drives Regwrite/writereg/Datawrite.
- Load results sit in a small FIFO; the ALU has priority, bounded by a starvation guard.
- Combinational pending-write query lets the issue stage stall on RAW hazards against queued or in-flight writes.

---
 rtl/regfile_wb_arbiter.sv | 151 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and load writeback onto the register file write port; ALU wins unless the load FIFO head has starved.
// ALU: Regwrite 1 cycle after acceptance; loads: 2 cycles via the FIFO. lsu_ready drops when full; alu_ready drops when starved.
module regfile_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [AW-1:0]            alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [AW-1:0]            lsu_rd,
    input  logic [XLEN-1:0]          lsu_data,
    output logic                     Regwrite,
    output logic [AW-1:0]            writereg,
    output logic [XLEN-1:0]          Datawrite,
    input  logic [AW-1:0]            chk_rs1,
    input  logic [AW-1:0]            chk_rs2,
    output logic                     hz_rs1,
    output logic                     hz_rs2,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [AW-1:0]   rd_mem  [DEPTH];
    logic [XLEN-1:0] dat_mem [DEPTH];

    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [LW-1:0]   count_q, count_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            regwrite_q, regwrite_d;
    logic [AW-1:0]   writereg_q, writereg_d;
    logic [XLEN-1:0] datawrite_q, datawrite_d;

    logic fifo_empty;
    logic fifo_full;
    logic alu_acc;
    logic push;
    logic pop;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == LW'(DEPTH));
    assign lsu_ready  = !fifo_full;
    assign alu_ready  = (starve_q != SW'(STARVE_MAX)) || fifo_empty;
    assign alu_acc    = alu_valid && alu_ready;
    // Loads to x0 complete the handshake but never occupy a slot.
    assign push       = lsu_valid && lsu_ready && (lsu_rd != '0);
    assign pop        = !alu_acc && !fifo_empty;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        starve_d    = starve_q;
        regwrite_d  = 1'b0;
        writereg_d  = writereg_q;
        datawrite_d = datawrite_q;

        if (push) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase

        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (alu_acc && (starve_q != SW'(STARVE_MAX))) begin
            starve_d = starve_q + SW'(1);
        end

        // Address/data only move when a real write is launched, so an x0 ALU op leaves them held.
        if (alu_acc) begin
            regwrite_d = (alu_rd != '0);
            if (alu_rd != '0) begin
                writereg_d  = alu_rd;
                datawrite_d = alu_data;
            end
        end else if (pop) begin
            regwrite_d  = 1'b1;
            writereg_d  = rd_mem[rptr_q];
            datawrite_d = dat_mem[rptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            regwrite_q  <= 1'b0;
            writereg_q  <= '0;
            datawrite_q <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            regwrite_q  <= regwrite_d;
            writereg_q  <= writereg_d;
            datawrite_q <= datawrite_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wptr_q]  <= lsu_rd;
            dat_mem[wptr_q] <= lsu_data;
        end
    end

    logic          hit1;
    logic          hit2;
    logic [PW-1:0] offs;

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        offs = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - rptr_q;
            if ({1'b0, offs} < count_q) begin
                if (rd_mem[i] == chk_rs1) hit1 = 1'b1;
                if (rd_mem[i] == chk_rs2) hit2 = 1'b1;
            end
        end
    end

    assign hz_rs1 = (chk_rs1 != '0) && (hit1 || (regwrite_q && (writereg_q == chk_rs1)));
    assign hz_rs2 = (chk_rs2 != '0) && (hit2 || (regwrite_q && (writereg_q == chk_rs2)));

    assign Regwrite   = regwrite_q;
    assign writereg   = writereg_q;
    assign Datawrite  = datawrite_q;
    assign fifo_level = count_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table of single writebacks plus directed starvation, full-FIFO and reset sequences.
module tb_regfile_wb_arbiter;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int DEPTH = 4;
    localparam int SMAX = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            alu_valid = 1'b0;
    logic            alu_ready;
    logic [AW-1:0]   alu_rd = '0;
    logic [XLEN-1:0] alu_data = '0;
    logic            lsu_valid = 1'b0;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_rd = '0;
    logic [XLEN-1:0] lsu_data = '0;
    logic            Regwrite;
    logic [AW-1:0]   writereg;
    logic [XLEN-1:0] Datawrite;
    logic [AW-1:0]   chk_rs1 = '0;
    logic [AW-1:0]   chk_rs2 = '0;
    logic            hz_rs1;
    logic            hz_rs2;
    logic [$clog2(DEPTH):0] fifo_level;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .Regwrite(Regwrite), .writereg(writereg), .Datawrite(Datawrite),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hz_rs1(hz_rs1), .hz_rs2(hz_rs2),
        .fifo_level(fifo_level)
    );

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_t;

    typedef struct packed {
        logic            is_lsu;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
        logic            exp_we;
        logic [2:0]      exp_lvl;
    } vec_t;

    wb_t  lsu_q[$];
    int   lsu_wr_cyc[$];
    logic alu_pend = 1'b0;
    logic alu_zero = 1'b0;
    wb_t  alu_exp = '0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: ALU writes must land the cycle after acceptance, loads pop in acceptance order.
    task automatic monitor();
        wb_t e;
        chk("hz_chk_zero", 64'(hz_rs2), 64'(0));
        if (alu_pend) begin
            chk("alu_wb", 64'({Regwrite, writereg, Datawrite}), 64'({1'b1, alu_exp}));
        end else if (alu_zero) begin
            chk("alu_rd0_no_write", 64'(Regwrite), 64'(0));
        end else if (Regwrite === 1'b1) begin
            if (lsu_q.size() == 0) begin
                chk("spurious_wb", 64'({Regwrite, writereg, Datawrite}), 64'(0));
            end else begin
                e = lsu_q.pop_front();
                chk("lsu_wb", 64'({Regwrite, writereg, Datawrite}), 64'({1'b1, e}));
                lsu_wr_cyc.push_back(cyc);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        monitor();
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] ard, input logic [XLEN-1:0] ad,
                         input logic lv, input logic [AW-1:0] lrd, input logic [XLEN-1:0] ld,
                         output logic a_acc, output logic l_acc);
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
        lsu_valid = lv;
        lsu_rd    = lrd;
        lsu_data  = ld;
        a_acc     = av && alu_ready;
        l_acc     = lv && lsu_ready;
        alu_pend  = a_acc && (ard != '0);
        alu_zero  = a_acc && (ard == '0);
        alu_exp   = '{rd: ard, data: ad};
        if (l_acc && (lrd != '0)) lsu_q.push_back('{rd: lrd, data: ld});
        tick();
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
    endtask

    logic aa, la;

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0, aa, la);
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        alu_pend  = 1'b0;
        alu_zero  = 1'b0;
        lsu_q.delete();
        tick();
        rst_n = 1'b1;
    endtask

    vec_t vecs[6];
    vec_t v;
    wb_t  last;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 5'd5,  32'hDEADBEEF, 1'b1, 3'd0};
        vecs[1] = '{1'b1, 5'd7,  32'h00001234, 1'b1, 3'd1};
        vecs[2] = '{1'b0, 5'd0,  32'hFFFFFFFF, 1'b0, 3'd0};
        vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 3'd0};
        vecs[4] = '{1'b1, 5'd15, 32'hA5A5A5A5, 1'b1, 3'd1};
        vecs[5] = '{1'b0, 5'd31, 32'h00000000, 1'b1, 3'd0};

        reset_dut();
        chk("rst_regwrite",  64'(Regwrite),   64'(0));
        chk("rst_writereg",  64'(writereg),   64'(0));
        chk("rst_datawrite", 64'(Datawrite),  64'(0));
        chk("rst_level",     64'(fifo_level), 64'(0));
        chk("rst_lsu_ready", 64'(lsu_ready),  64'(1));
        chk("rst_alu_ready", 64'(alu_ready),  64'(1));
        chk("rst_hz1",       64'(hz_rs1),     64'(0));

        last = '0;
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            chk_rs1 = v.rd;
            if (v.is_lsu) drive(1'b0, '0, '0, 1'b1, v.rd, v.data, aa, la);
            else          drive(1'b1, v.rd, v.data, 1'b0, '0, '0, aa, la);
            chk("vec_accept",   64'(v.is_lsu ? la : aa), 64'(1));
            chk("vec_we_t1",    64'(Regwrite),   64'(!v.is_lsu && v.exp_we));
            chk("vec_level_t1", 64'(fifo_level), 64'(v.exp_lvl));
            chk("vec_hz_t1",    64'(hz_rs1),     64'(v.exp_we));
            if (v.exp_we) last = '{rd: v.rd, data: v.data};
            idle();
            chk("vec_we_t2",    64'(Regwrite),   64'(v.is_lsu && v.exp_we));
            chk("vec_hz_t2",    64'(hz_rs1),     64'(v.is_lsu && v.exp_we));
            chk("vec_out_t2",   64'({writereg, Datawrite}), 64'(last));
            idle();
            chk("vec_we_t3",    64'(Regwrite),   64'(0));
            chk("vec_hold_t3",  64'({writereg, Datawrite}), 64'(last));
            chk("vec_hz_t3",    64'(hz_rs1),     64'(0));
            chk("vec_level_t3", 64'(fifo_level), 64'(0));
        end
        chk_rs1 = '0;

        // Fill the FIFO behind continuous ALU traffic, then watch the starvation guard and a refused push.
        reset_dut();
        lsu_wr_cyc.delete();
        for (int i = 0; i < DEPTH; i++) begin
            chk("fill_lsu_ready", 64'(lsu_ready), 64'(1));
            drive(1'b1, 5'(16 + i), $urandom, 1'b1, 5'(i + 1), 32'h100 + i, aa, la);
        end
        chk("full_level",        64'(fifo_level), 64'(DEPTH));
        chk("full_lsu_ready",    64'(lsu_ready),  64'(0));
        chk("starved_alu_ready", 64'(alu_ready),  64'(0));
        drive(1'b1, 5'd20, 32'h0BADF00D, 1'b1, 5'd5, 32'h105, aa, la);
        chk("full_push_refused", 64'(la),         64'(0));
        chk("pop_level",         64'(fifo_level), 64'(DEPTH - 1));
        chk("alu_ready_resume",  64'(alu_ready),  64'(1));
        drive(1'b1, 5'd20, 32'h0BADF00D, 1'b1, 5'd5, 32'h105, aa, la);
        chk("push_after_pop",    64'(la),         64'(1));
        chk("refill_level",      64'(fifo_level), 64'(DEPTH));
        for (int i = 0; i < 40 && fifo_level != 0; i++) begin
            drive(1'b1, 5'(16 + (i % 16)), $urandom, 1'b0, '0, '0, aa, la);
        end
        chk("drain_level",     64'(fifo_level),        64'(0));
        chk("drain_sb_empty",  64'(lsu_q.size()),      64'(0));
        chk("drain_lsu_count", 64'(lsu_wr_cyc.size()), 64'(5));
        for (int i = 1; i < lsu_wr_cyc.size(); i++) begin
            chk("starve_gap_ok", 64'((lsu_wr_cyc[i] - lsu_wr_cyc[i-1]) <= SMAX + 1), 64'(1));
        end

        // Mid-operation reset with queued loads and a write in the output stage.
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(24 + i), $urandom, 1'b1, 5'(8 + i), 32'h200 + i, aa, la);
        end
        drive(1'b1, 5'd28, 32'hCAFEF00D, 1'b0, '0, '0, aa, la);
        chk("pre_rst_level", 64'(fifo_level), 64'(3));
        chk("pre_rst_we",    64'(Regwrite),   64'(1));
        reset_dut();
        chk("mid_rst_we",        64'(Regwrite),   64'(0));
        chk("mid_rst_level",     64'(fifo_level), 64'(0));
        chk("mid_rst_alu_ready", 64'(alu_ready),  64'(1));
        chk("mid_rst_lsu_ready", 64'(lsu_ready),  64'(1));
        chk_rs1 = 5'd8;
        chk("mid_rst_hz",        64'(hz_rs1),     64'(0));
        for (int i = 0; i < 8; i++) idle();
        chk("post_rst_quiet",    64'(Regwrite),   64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
